// File: rtl/stream_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO with cut-through fallback for packets
// larger than the buffer, plus fill/packet-count observability outputs.
module stream_pkt_fifo #(
  parameter  int unsigned DATA_WIDTH = 512,
  parameter  int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter  int unsigned USER_WIDTH = 64,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ins_data,
  input  logic [KEEP_WIDTH-1:0] ins_keep,
  input  logic [USER_WIDTH-1:0] ins_user,
  input  logic                  ins_valid,
  input  logic                  ins_last,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] ots_data,
  output logic [KEEP_WIDTH-1:0] ots_keep,
  output logic [USER_WIDTH-1:0] ots_user,
  output logic                  ots_valid,
  output logic                  ots_last,
  input  logic                  ots_ready,
  output logic [AW:0]           fill_level,
  output logic [AW:0]           pkt_count,
  output logic                  ct_active
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic          ct_active_q, ct_active_d;
  logic          empty, full, wr_fire, rd_fire, wr_eop, rd_eop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign ins_ready  = !full;
  assign {ots_data, ots_keep, ots_user, ots_last} = mem_q[rd_ptr_q[AW-1:0]];
  assign ots_valid  = !empty && ((pkt_count_q != '0) || ct_active_q);
  assign fill_level = wr_ptr_q - rd_ptr_q;
  assign pkt_count  = pkt_count_q;
  assign ct_active  = ct_active_q;

  assign wr_fire = ins_valid && ins_ready;
  assign rd_fire = ots_valid && ots_ready;
  assign wr_eop  = wr_fire && ins_last;
  assign rd_eop  = rd_fire && ots_last;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ins_data, ins_keep, ins_user, ins_last};
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_count_d = pkt_count_q;
    ct_active_d = ct_active_q;

    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);

    if (wr_eop && !rd_eop)      pkt_count_d = pkt_count_q + PW'(1);
    else if (!wr_eop && rd_eop) pkt_count_d = pkt_count_q - PW'(1);

    // Full with no complete packet means an oversize packet: release it early.
    if (rd_eop)                               ct_active_d = 1'b0;
    else if (full && (pkt_count_q == '0))     ct_active_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      ct_active_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      ct_active_q <= ct_active_d;
    end
  end

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Directed bench for stream_pkt_fifo: latency, full/drain, cut-through, concurrent
// last read/write, randomised backpressure stream and mid-packet reset.
module tb_stream_pkt_fifo;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;
  localparam int unsigned UW = 64;
  localparam int unsigned AW = 4;

  typedef logic [DW+KW+UW:0] ent_t;

  logic          clk, rst_n;
  logic [DW-1:0] ins_data;
  logic [KW-1:0] ins_keep;
  logic [UW-1:0] ins_user;
  logic          ins_valid, ins_last, ins_ready;
  logic [DW-1:0] ots_data;
  logic [KW-1:0] ots_keep;
  logic [UW-1:0] ots_user;
  logic          ots_valid, ots_last, ots_ready;
  logic [AW:0]   fill_level, pkt_count;
  logic          ct_active;

  int n_err = 0;
  int n_chk = 0;

  // Stream scoreboard state
  int   plen[$];
  ent_t sb[$];
  int   pid_base, pi, bi, pkts_out, rdy_pct;

  stream_pkt_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .ins_data(ins_data), .ins_keep(ins_keep), .ins_user(ins_user),
    .ins_valid(ins_valid), .ins_last(ins_last), .ins_ready(ins_ready),
    .ots_data(ots_data), .ots_keep(ots_keep), .ots_user(ots_user),
    .ots_valid(ots_valid), .ots_last(ots_last), .ots_ready(ots_ready),
    .fill_level(fill_level), .pkt_count(pkt_count), .ct_active(ct_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] tagw(input int p, input int b);
    tagw = {p[15:0], b[15:0]};
  endfunction

  function automatic logic [DW-1:0] mk_data(input int p, input int b);
    mk_data = {16{tagw(p, b)}};
  endfunction

  function automatic logic [KW-1:0] mk_keep(input int p, input int b);
    mk_keep = {tagw(p, b) ^ 32'h5a5a_0f0f, tagw(p, b)};
  endfunction

  function automatic logic [UW-1:0] mk_user(input int p, input int b);
    mk_user = {~tagw(p, b), tagw(p, b) ^ 32'h1234_5678};
  endfunction

  function automatic ent_t mk_ent(input int p, input int b, input logic last);
    mk_ent = {mk_data(p, b), mk_keep(p, b), mk_user(p, b), last};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input int b, input logic last);
    ins_valid = 1'b1;
    ins_data  = mk_data(p, b);
    ins_keep  = mk_keep(p, b);
    ins_user  = mk_user(p, b);
    ins_last  = last;
  endtask

  task automatic idle_in();
    ins_valid = 1'b0;
    ins_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int p, input int b, input logic last);
    chk1({tag, "_valid"}, ots_valid, 1'b1);
    chkn({tag, "_beat"}, 1024'({ots_data, ots_keep, ots_user, ots_last}),
         1024'(mk_ent(p, b, last)));
  endtask

  task automatic chk_counts(input string tag, input int fill, input int pkts);
    chkn({tag, "_fill"}, 1024'(fill_level), 1024'(fill));
    chkn({tag, "_pkts"}, 1024'(pkt_count), 1024'(pkts));
  endtask

  task automatic do_reset();
    idle_in();
    ots_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) step();
    chk1("rst_ots_valid", ots_valid, 1'b0);
    chk1("rst_ins_ready", ins_ready, 1'b1);
    chk1("rst_ct_active", ct_active, 1'b0);
    chk_counts("rst", 0, 0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic init_stream(input int base);
    plen.delete();
    sb.delete();
    pid_base = base;
    pi       = 0;
    bi       = 0;
    pkts_out = 0;
  endtask

  // One clock of scoreboarded streaming traffic.
  task automatic cycle();
    logic in_fire, out_fire;
    if (pi < plen.size()) drive(pid_base + pi, bi, (bi == plen[pi] - 1));
    else idle_in();
    ots_ready = ($urandom_range(99) < rdy_pct);
    #1;
    if (ots_valid) begin
      chk1("stream_have_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0)
        chkn("stream_beat", 1024'({ots_data, ots_keep, ots_user, ots_last}), 1024'(sb[0]));
    end
    out_fire = ots_valid && ots_ready;
    in_fire  = ins_valid && ins_ready;
    if (out_fire && (sb.size() != 0)) begin
      if (sb[0][0]) pkts_out++;
      void'(sb.pop_front());
    end
    if (in_fire) begin
      sb.push_back({ins_data, ins_keep, ins_user, ins_last});
      if (ins_last) begin
        pi++;
        bi = 0;
      end else begin
        bi++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    while (!((pi == plen.size()) && (sb.size() == 0)) && (n < budget)) begin
      cycle();
      n++;
    end
    chk1({tag, "_completed_in_budget"}, ((pi == plen.size()) && (sb.size() == 0)), 1'b1);
    idle_in();
    ots_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    ots_ready = 1'b0;
    ins_data  = '0;
    ins_keep  = '0;
    ins_user  = '0;
    idle_in();
    rdy_pct   = 0;

    // 1: store-and-forward latency of a 3-beat packet
    do_reset();
    ots_ready = 1'b1;
    drive(1, 0, 1'b0); step();
    chk1("t1_valid_after_b0", ots_valid, 1'b0);
    drive(1, 1, 1'b0); step();
    chk1("t1_valid_after_b1", ots_valid, 1'b0);
    drive(1, 2, 1'b1); step();
    idle_in();
    chk_counts("t1_complete", 3, 1);
    for (int b = 0; b < 3; b++) begin
      chk_out("t1_out", 1, b, (b == 2));
      step();
    end
    chk1("t1_valid_drained", ots_valid, 1'b0);
    chk_counts("t1_drained", 0, 0);

    // 2: fill with four 4-beat packets, then drain
    ots_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(10 + i / 4, i % 4, ((i % 4) == 3));
      step();
    end
    idle_in();
    chk_counts("t2_full", 16, 4);
    chk1("t2_ins_ready_full", ins_ready, 1'b0);
    chk1("t2_ct_idle", ct_active, 1'b0);
    ots_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_out("t2_out", 10 + i / 4, i % 4, ((i % 4) == 3));
      step();
    end
    ots_ready = 1'b0;
    chk_counts("t2_drained", 0, 0);
    chk1("t2_ins_ready_empty", ins_ready, 1'b1);

    // 3: oversize 20-beat packet triggers cut-through
    init_stream(20);
    plen.push_back(20);
    rdy_pct = 0;
    repeat (16) cycle();
    chk_counts("t3_full", 16, 0);
    chk1("t3_ins_ready_full", ins_ready, 1'b0);
    chk1("t3_ct_not_yet", ct_active, 1'b0);
    cycle();
    chk1("t3_ct_set", ct_active, 1'b1);
    chk1("t3_valid_ct", ots_valid, 1'b1);
    chk_counts("t3_ct", 16, 0);
    rdy_pct = 100;
    run_until_done(200, "t3");
    chk1("t3_ct_cleared", ct_active, 1'b0);
    chkn("t3_pkts_out", 1024'(pkts_out), 1024'(1));
    chk_counts("t3_end", 0, 0);

    // 4: last-beat write and last-beat read in the same cycle
    ots_ready = 1'b0;
    drive(30, 0, 1'b0); step();
    drive(30, 1, 1'b1); step();
    drive(31, 0, 1'b0); step();
    idle_in();
    ots_ready = 1'b1;
    chk_out("t4_a0", 30, 0, 1'b0);
    step();
    chk_counts("t4_before", 2, 1);
    chk_out("t4_a1", 30, 1, 1'b1);
    drive(31, 1, 1'b1);
    step();
    idle_in();
    chk_counts("t4_after", 2, 1);
    chk_out("t4_b0", 31, 0, 1'b0);
    step();
    chk_out("t4_b1", 31, 1, 1'b1);
    step();
    ots_ready = 1'b0;
    chk1("t4_valid_drained", ots_valid, 1'b0);
    chk_counts("t4_drained", 0, 0);

    // 5: 200 packets of 1..40 beats under 50% backpressure
    init_stream(100);
    for (int i = 0; i < 200; i++) plen.push_back(int'($urandom_range(1, 40)));
    rdy_pct = 50;
    run_until_done(40000, "t5");
    chkn("t5_pkts_out", 1024'(pkts_out), 1024'(200));
    chk_counts("t5_end", 0, 0);
    chk1("t5_ct_idle", ct_active, 1'b0);

    // 6: reset mid-packet with seven beats stored
    for (int i = 0; i < 7; i++) begin
      if (i < 3) drive(40, i, (i == 2));
      else       drive(41, i - 3, 1'b0);
      step();
    end
    idle_in();
    chk_counts("t6_before", 7, 1);
    chk1("t6_valid_before", ots_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_valid", ots_valid, 1'b0);
    chk1("t6_rst_ins_ready", ins_ready, 1'b1);
    chk1("t6_rst_ct", ct_active, 1'b0);
    chk_counts("t6_rst", 0, 0);
    step();
    rst_n = 1'b1;
    step();
    init_stream(50);
    plen.push_back(2);
    rdy_pct = 100;
    run_until_done(50, "t6");
    chkn("t6_pkts_out", 1024'(pkts_out), 1024'(1));
    chk_counts("t6_end", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
